// File: rtl/common_pkg.sv
// Shared types for the warp pipeline: instruction word, warp phase and fetch FSM state.
package common_pkg;

    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        WARP_IDLE,
        WARP_FETCH,
        WARP_DECODE,
        WARP_EXEC
    } warp_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT,
        F_DONE
    } fetcher_state_t;

endpackage

// File: rtl/fetcher_if.sv
// Program-memory read port: valid/ready request channel plus a response strobe with data.
interface fetcher_if;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

endinterface

// File: rtl/fetcher.sv
// Instruction fetch with a single-entry word buffer; hit -> fetch_done after 1 cycle, miss -> 2 cycles + memory delays.
// Request held steady while mem_req_ready is low; withdrawn only if the warp leaves fetch before acceptance.
module fetcher
    import common_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  warp_state_t       warp_state,
    input  logic [31:0]       pc,
    input  logic              inval,
    fetcher_if.master         mem,
    output instr_t            instr,
    output logic              fetch_done
);

    fetcher_state_t state_q, state_d;
    instr_t         instr_q, instr_d;
    logic [29:0]    buf_tag_q, buf_tag_d;
    logic           buf_valid_q, buf_valid_d;

    logic [31:0]    req_addr;
    logic           in_fetch;
    logic           hit;
    logic           resp_load;

    // Byte offset bits never reach the address or the tag.
    assign req_addr  = pc & 32'hFFFF_FFFC;
    assign in_fetch  = (warp_state == WARP_FETCH);
    assign hit       = buf_valid_q && (buf_tag_q == req_addr[31:2]);
    assign resp_load = (state_q == F_WAIT) && mem.mem_resp_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= F_IDLE;
            instr_q     <= '0;
            buf_tag_q   <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            buf_tag_q   <= buf_tag_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        buf_tag_d   = buf_tag_q;
        buf_valid_d = buf_valid_q;

        case (state_q)
            F_IDLE: begin
                if (in_fetch) state_d = hit ? F_DONE : F_REQ;
            end
            F_REQ: begin
                // Acceptance takes priority over a simultaneous exit from fetch.
                if (mem.mem_req_ready) state_d = F_WAIT;
                else if (!in_fetch)    state_d = F_IDLE;
            end
            F_WAIT: begin
                if (resp_load) begin
                    state_d     = F_DONE;
                    instr_d     = mem.mem_resp_data;
                    buf_tag_d   = req_addr[31:2];
                    buf_valid_d = 1'b1;
                end
            end
            F_DONE: begin
                if (!in_fetch) state_d = F_IDLE;
            end
            default: state_d = F_IDLE;
        endcase

        if (inval) buf_valid_d = 1'b0;
    end

    always_comb begin
        mem.mem_req_valid = (state_q == F_REQ);
        mem.mem_req_addr  = req_addr;
        fetch_done        = (state_q == F_DONE);
        instr             = instr_q;
    end

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: miss, hit, backpressure, abort, inval race and async reset.
module tb_fetcher;
    import common_pkg::*;

    logic        clk;
    logic        reset;
    warp_state_t warp_state;
    logic [31:0] pc;
    logic        inval;
    instr_t      instr;
    logic        fetch_done;

    int vectors;
    int miscompares;

    fetcher_if mif();

    fetcher dut (
        .clk        (clk),
        .reset      (reset),
        .warp_state (warp_state),
        .pc         (pc),
        .inval      (inval),
        .mem        (mif.master),
        .instr      (instr),
        .fetch_done (fetch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        warp_state  = WARP_IDLE;
        pc          = 32'h0;
        inval       = 1'b0;
        mif.mem_req_ready  = 1'b0;
        mif.mem_resp_valid = 1'b0;
        mif.mem_resp_data  = 32'h0;
        #2 reset = 1'b0;
        #1;
        chk("rst_instr", instr, 32'h0);
        chk("rst_done", {31'b0, fetch_done}, 32'd0);
        chk("rst_req", {31'b0, mif.mem_req_valid}, 32'd0);
        cyc();
        cyc();
        reset = 1'b1;

        // Miss on 0x100: ready on first request cycle, response two cycles later.
        warp_state = WARP_FETCH;
        pc = 32'h100;
        mif.mem_req_ready = 1'b1;
        chk("miss_idle_req", {31'b0, mif.mem_req_valid}, 32'd0);
        cyc();
        chk("miss_req_vld", {31'b0, mif.mem_req_valid}, 32'd1);
        chk("miss_req_addr", mif.mem_req_addr, 32'h100);
        cyc();
        mif.mem_req_ready = 1'b0;
        chk("miss_req_once", {31'b0, mif.mem_req_valid}, 32'd0);
        cyc();
        chk("miss_wait_done", {31'b0, fetch_done}, 32'd0);
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data  = 32'h00500093;
        cyc();
        mif.mem_resp_valid = 1'b0;
        chk("miss_done", {31'b0, fetch_done}, 32'd1);
        chk("miss_instr", instr, 32'h00500093);
        warp_state = WARP_IDLE;
        cyc();
        chk("miss_leave", {31'b0, fetch_done}, 32'd0);

        // Hit on the same word, low pc bits differ.
        warp_state = WARP_FETCH;
        pc = 32'h103;
        cyc();
        chk("hit_done", {31'b0, fetch_done}, 32'd1);
        chk("hit_no_req", {31'b0, mif.mem_req_valid}, 32'd0);
        chk("hit_instr", instr, 32'h00500093);
        warp_state = WARP_IDLE;
        cyc();

        // Backpressure: ready low three cycles, accepted on the fourth.
        warp_state = WARP_FETCH;
        pc = 32'h202;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("bp_vld", {31'b0, mif.mem_req_valid}, 32'd1);
            chk("bp_addr", mif.mem_req_addr, 32'h200);
            if (i == 3) mif.mem_req_ready = 1'b1;
            else cyc();
        end
        cyc();
        mif.mem_req_ready = 1'b0;
        chk("bp_single", {31'b0, mif.mem_req_valid}, 32'd0);
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data  = 32'hDEADBEEF;
        cyc();
        mif.mem_resp_valid = 1'b0;
        chk("bp_done", {31'b0, fetch_done}, 32'd1);
        chk("bp_instr", instr, 32'hDEADBEEF);
        warp_state = WARP_IDLE;
        cyc();

        // Abort while requesting with ready low.
        warp_state = WARP_FETCH;
        pc = 32'h300;
        cyc();
        chk("abort_req_vld", {31'b0, mif.mem_req_valid}, 32'd1);
        warp_state = WARP_IDLE;
        cyc();
        chk("abort_withdrawn", {31'b0, mif.mem_req_valid}, 32'd0);
        cyc();
        chk("abort_stays_idle", {31'b0, mif.mem_req_valid}, 32'd0);

        // Leave fetch while waiting: response still consumed.
        warp_state = WARP_FETCH;
        mif.mem_req_ready = 1'b1;
        cyc();
        cyc();
        mif.mem_req_ready = 1'b0;
        warp_state = WARP_IDLE;
        cyc();
        chk("wait_abort_done", {31'b0, fetch_done}, 32'd0);
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data  = 32'h11111111;
        cyc();
        mif.mem_resp_valid = 1'b0;
        chk("wait_abort_fd", {31'b0, fetch_done}, 32'd1);
        chk("wait_abort_instr", instr, 32'h11111111);
        cyc();
        chk("wait_abort_exit", {31'b0, fetch_done}, 32'd0);
        warp_state = WARP_FETCH;
        cyc();
        chk("wait_abort_hit", {31'b0, fetch_done}, 32'd1);
        warp_state = WARP_IDLE;
        cyc();

        // Response outside F_WAIT is ignored.
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data  = 32'h22222222;
        cyc();
        mif.mem_resp_valid = 1'b0;
        chk("stray_resp", instr, 32'h11111111);

        // Inval coinciding with the response load for 0x104.
        warp_state = WARP_FETCH;
        pc = 32'h104;
        mif.mem_req_ready = 1'b1;
        cyc();
        cyc();
        mif.mem_req_ready = 1'b0;
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data  = 32'h33333333;
        inval = 1'b1;
        cyc();
        mif.mem_resp_valid = 1'b0;
        inval = 1'b0;
        chk("inval_instr", instr, 32'h33333333);
        chk("inval_done", {31'b0, fetch_done}, 32'd1);
        warp_state = WARP_IDLE;
        cyc();
        warp_state = WARP_FETCH;
        cyc();
        chk("inval_miss", {31'b0, mif.mem_req_valid}, 32'd1);
        chk("inval_miss_fd", {31'b0, fetch_done}, 32'd0);
        mif.mem_req_ready = 1'b1;
        cyc();
        mif.mem_req_ready = 1'b0;
        mif.mem_resp_valid = 1'b1;
        cyc();
        mif.mem_resp_valid = 1'b0;
        chk("refill_done", {31'b0, fetch_done}, 32'd1);
        warp_state = WARP_IDLE;
        cyc();

        // Async reset in F_WAIT, late response afterwards.
        warp_state = WARP_FETCH;
        pc = 32'h400;
        mif.mem_req_ready = 1'b1;
        cyc();
        cyc();
        mif.mem_req_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_instr", instr, 32'h0);
        chk("arst_done", {31'b0, fetch_done}, 32'd0);
        chk("arst_req", {31'b0, mif.mem_req_valid}, 32'd0);
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data  = 32'h44444444;
        cyc();
        cyc();
        mif.mem_resp_valid = 1'b0;
        chk("arst_late_instr", instr, 32'h0);
        chk("arst_late_done", {31'b0, fetch_done}, 32'd0);
        pc = 32'h104;
        reset = 1'b1;
        cyc();
        chk("arst_buf_cleared", {31'b0, mif.mem_req_valid}, 32'd1);
        chk("arst_no_done", {31'b0, fetch_done}, 32'd0);
        warp_state = WARP_IDLE;
        cyc();
        chk("arst_withdraw", {31'b0, mif.mem_req_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port warp_state, input, warp_state_t: current warp phase; fetch is active only in WARP_FETCH.
REQ-004 The block SHALL have the port pc, input, 32 bits: byte address of the instruction to fetch; stable while warp_state==WARP_FETCH.
REQ-005 The block SHALL have the port inval, input, 1 bit: invalidates the instruction buffer (program reload).
REQ-006 The block SHALL have the port mem_req_valid, output, 1 bit: program-memory read request.
REQ-007 The block SHALL have the port mem_req_addr, output, 32 bits: request word address, {pc[31:2],2'b00}.
REQ-008 The block SHALL have the port mem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-009 The block SHALL have the port mem_resp_valid, input, 1 bit: response data valid.
REQ-010 The block SHALL have the port mem_resp_data, input, 32 bits: fetched instruction word.
REQ-011 The block SHALL have the port instr, output, instr_t: registered instruction presented to the decoder.
REQ-012 The block SHALL have the port fetch_done, output, 1 bit: instr is valid for the current pc.

Function
REQ-013 The FSM SHALL have the states F_IDLE, F_REQ, F_WAIT and F_DONE.
REQ-014 In F_IDLE with warp_state==WARP_FETCH, a buffer hit (buf_valid and buf_tag==pc[31:2]) SHALL go to F_DONE next cycle with no memory request; a miss SHALL go to F_REQ.
REQ-015 In F_REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL be {pc[31:2],2'b00}; when mem_req_ready==1, the FSM SHALL go to F_WAIT.
REQ-016 mem_req_valid SHALL be 0 in every state other than F_REQ.
REQ-017 In F_WAIT, on mem_resp_valid the block SHALL load instr<=mem_resp_data, buf_tag<=pc[31:2] and buf_valid<=1, and go to F_DONE.
REQ-018 fetch_done SHALL be 1 exactly while in F_DONE; F_DONE SHALL return to F_IDLE when warp_state!=WARP_FETCH.
REQ-019 instr SHALL change only on the response load in F_WAIT; on a hit, the held instr is the buffered word.
REQ-020 Hit latency SHALL be 1 cycle from entry to WARP_FETCH to fetch_done; miss latency SHALL be 2 cycles plus memory ready and response delays.
REQ-021 If warp_state leaves WARP_FETCH while in F_REQ, the request SHALL be withdrawn and the FSM SHALL go to F_IDLE, provided ready was not sampled high that cycle.
REQ-022 If warp_state leaves WARP_FETCH while in F_WAIT, the FSM SHALL still wait for and consume the outstanding response, then go to F_DONE.
REQ-023 mem_resp_valid outside F_WAIT SHALL be ignored.
REQ-024 A response in the same cycle as acceptance SHALL NOT be permitted; a response is consumed no earlier than the cycle after the F_REQ to F_WAIT transition.
REQ-025 inval SHALL clear buf_valid next cycle; when inval coincides with a response load, inval SHALL win (buf_valid=0), but instr still loads and F_DONE is still reached.
REQ-026 pc[1:0] SHALL be ignored in address and tag computation.

Reset
REQ-027 On reset==0, the block SHALL immediately set state=F_IDLE, instr=0, buf_valid=0, buf_tag=0, mem_req_valid=0 and fetch_done=0.
REQ-028 Reset asserted in F_WAIT SHALL abandon the outstanding response, and a late response after reset SHALL be ignored per REQ-023.

Structure
REQ-029 fetcher_state_t (F_IDLE, F_REQ, F_WAIT, F_DONE) SHALL be added to common_pkg, alongside the existing instr_t and warp_state_t.
REQ-030 The block SHALL have no sub-modules; the FSM and the single-entry buffer (tag, valid, data = instr register) SHALL live in one module.

Verification
REQ-031 Miss: pc=0x100, ready=1 on first F_REQ cycle, resp 2 cycles later with 0x00500093 -> mem_req_addr=0x100 for 1 cycle, instr=0x00500093, fetch_done high 4 cycles after WARP_FETCH entry.
REQ-032 Hit: re-enter WARP_FETCH with pc=0x100 -> mem_req_valid stays 0, fetch_done 1 cycle later, instr unchanged.
REQ-033 Backpressure: ready low 3 cycles -> mem_req_valid and addr held steady 4 cycles, then a single acceptance.
REQ-034 Abort: warp_state leaves WARP_FETCH in F_REQ with ready=0 -> F_IDLE, no request next cycle; leaving in F_WAIT -> response still consumed.
REQ-035 Inval race: inval coincides with the response for pc=0x104 -> instr loaded, fetch_done=1, then the next fetch of 0x104 misses.
REQ-036 Async reset in F_WAIT, then a response arrives -> outputs 0 immediately, response ignored, buf_valid=0.
